// File: rtl/fir_pkg.sv
// Shared definitions for the FIR block sequencer: controller states, block size
// and the coefficient set loaded at reset.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } fir_state_t;

    localparam int P     = 6;
    localparam int IDX_W = 3;
    localparam int N_COEF = 4;

    localparam int C0_DEF = -1;
    localparam int C1_DEF = -1;
    localparam int C2_DEF = -2;
    localparam int C3_DEF = 3;

    function automatic int coef_default(input int i);
        case (i)
            0:       return C0_DEF;
            1:       return C1_DEF;
            2:       return C2_DEF;
            default: return C3_DEF;
        endcase
    endfunction

endpackage

// File: rtl/fir_drain.sv
// Result unloader: captures one block of FIR outputs and presents them one per
// valid/ready transfer, index 0 first.
module fir_drain
    import fir_pkg::*;
#(
    parameter int Y_OUT = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [P*Y_OUT-1:0] y_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [Y_OUT-1:0]   data_o,
    output logic               last_o
);

    logic [Y_OUT-1:0] y_arr    [P];
    logic [Y_OUT-1:0] buf_q    [P];
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic [Y_OUT-1:0] data_q;

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_unpack
            assign y_arr[gi] = y_i[gi*Y_OUT +: Y_OUT];
        end
    endgenerate

    // data_q is preloaded with the next entry so it is a plain register output.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            for (int k = 0; k < P; k++) buf_q[k] <= '0;
        end else if (load_i) begin
            for (int k = 0; k < P; k++) buf_q[k] <= y_arr[k];
            idx_q   <= '0;
            valid_q <= 1'b1;
            data_q  <= y_arr[0];
        end else if (valid_q && ready_i) begin
            if (idx_q == IDX_W'(P - 1)) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
                data_q <= buf_q[idx_q + IDX_W'(1)];
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = (idx_q == IDX_W'(P - 1));

endmodule

// File: rtl/fir_seq_ctrl.sv
// Block sequencer around a 6-parallel FIR: gathers serial samples into a block,
// issues it, waits (with timeout) for the results and streams them back out.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int W_IN  = 5,
    parameter int C_IN  = 3,
    parameter int Y_OUT = 12,
    parameter int TMO   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [C_IN-1:0]    cfg_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [W_IN-1:0]    s_data,
    output logic [C_IN-1:0]    c_0,
    output logic [C_IN-1:0]    c_1,
    output logic [C_IN-1:0]    c_2,
    output logic [C_IN-1:0]    c_3,
    output logic [P*W_IN-1:0]  blk_x,
    output logic               blk_valid,
    input  logic [P*Y_OUT-1:0] fir_y,
    input  logic               fir_y_valid,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [Y_OUT-1:0]   m_data,
    output logic               err_tmo
);

    localparam int TMR_W = (TMO < 2) ? 1 : $clog2(TMO);

    fir_state_t        state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [C_IN-1:0]   coef_q [N_COEF];
    logic [W_IN-1:0]   samp_q [P];
    logic [P*W_IN-1:0] blk_x_q;
    logic              blk_valid_q;
    logic              s_ready_q;
    logic              err_q;

    logic s_fire;
    logic y_load;
    logic drain_last;

    assign s_fire = s_valid && s_ready_q;
    assign y_load = (state_q == WAIT) && fir_y_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmr_q       <= '0;
            blk_x_q     <= '0;
            blk_valid_q <= 1'b0;
            s_ready_q   <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < N_COEF; k++) coef_q[k] <= C_IN'(coef_default(k));
            for (int k = 0; k < P; k++) samp_q[k] <= '0;
        end else begin
            blk_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_we) coef_q[cfg_addr] <= cfg_data;
                    if (run) begin
                        state_q   <= FILL;
                        s_ready_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                FILL: begin
                    // A transfer always wins over run=0 so a started block completes.
                    if (s_fire) begin
                        samp_q[cnt_q] <= s_data;
                        if (cnt_q == IDX_W'(P - 1)) begin
                            cnt_q <= '0;
                            for (int k = 0; k < P - 1; k++)
                                blk_x_q[k*W_IN +: W_IN] <= samp_q[k];
                            blk_x_q[(P-1)*W_IN +: W_IN] <= s_data;
                            blk_valid_q <= 1'b1;
                            s_ready_q   <= 1'b0;
                            state_q     <= ISSUE;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end else if (!run && cnt_q == '0) begin
                        s_ready_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                ISSUE: begin
                    tmr_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A result arriving in the TMO-th cycle after issue is still accepted.
                    if (fir_y_valid) begin
                        state_q <= DRAIN;
                    end else if (tmr_q == TMR_W'(TMO - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready && drain_last) begin
                        if (run) begin
                            state_q   <= FILL;
                            s_ready_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    fir_drain #(
        .Y_OUT(Y_OUT)
    ) u_drain (
        .clk     (clk),
        .rst     (rst),
        .load_i  (y_load),
        .y_i     (fir_y),
        .ready_i (m_ready),
        .valid_o (m_valid),
        .data_o  (m_data),
        .last_o  (drain_last)
    );

    assign s_ready   = s_ready_q;
    assign c_0       = coef_q[0];
    assign c_1       = coef_q[1];
    assign c_2       = coef_q[2];
    assign c_3       = coef_q[3];
    assign blk_x     = blk_x_q;
    assign blk_valid = blk_valid_q;
    assign err_tmo   = err_q;

endmodule
